uart_cmd_handler: RTL and testbench

Command decoder between the UART FIFO pair and the settings register bank. It pops command bytes from the UART receive FIFO and executes them: UART reset, 16-bit register write, or 16-bit register read. Read data is returned as bytes pushed into the UART transmit FIFO. It sits in the communication-and-control subsystem, one instance per UART link.

---
 rtl/uart_cmd_handler.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_handler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_handler.sv
// UART command decoder: pops frames from the RX FIFO, runs reset/register write/register read, replies on the TX FIFO.
// Two cycles per received byte; fetches wait while RX is empty, reply pushes stall while TX is full.
module uart_cmd_handler #(
    parameter int BUFFER_WIDTH        = 8,
    parameter int SETTINGS_ADDR_WIDTH = 8,
    parameter int SETTINGS_DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rstb,
    output logic                           uart_rst,
    input  logic [BUFFER_WIDTH-1:0]        uart_data_out,
    input  logic                           uart_out_full,
    input  logic                           uart_out_empty,
    output logic                           uart_out_read,
    output logic [BUFFER_WIDTH-1:0]        uart_data_in,
    output logic                           uart_in_write,
    input  logic                           uart_in_full,
    input  logic                           uart_in_empty,
    output logic [SETTINGS_ADDR_WIDTH-1:0] settings_addr,
    input  logic [SETTINGS_DATA_WIDTH-1:0] settings_data_in,
    output logic [SETTINGS_DATA_WIDTH-1:0] settings_data_out,
    output logic                           settings_write_en
);

    localparam logic [BUFFER_WIDTH-1:0] OP_UARTRST  = BUFFER_WIDTH'(8'h01);
    localparam logic [BUFFER_WIDTH-1:0] OP_WRITEREG = BUFFER_WIDTH'(8'h02);
    localparam logic [BUFFER_WIDTH-1:0] OP_READREG  = BUFFER_WIDTH'(8'h03);

    typedef enum logic [3:0] {
        IDLE,
        FETCH_OP,
        DECODE,
        FETCH_ADDR,
        FETCH_DH,
        FETCH_DL,
        REG_WRITE,
        REG_READ,
        READ_WAIT,
        SEND_HI,
        SEND_LO,
        UART_RESET
    } state_t;

    state_t                         state_q, state_d;
    logic                           pend_q, pend_d;
    logic [BUFFER_WIDTH-1:0]        op_q, op_d;
    logic [BUFFER_WIDTH-1:0]        hi_q, hi_d;
    logic [SETTINGS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SETTINGS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SETTINGS_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                           is_fetch;
    logic                           byte_rdy;

    // Status-only FIFO flags are intentionally ignored.
    logic unused_status;
    assign unused_status = uart_out_full ^ uart_in_empty;

    assign is_fetch = (state_q == FETCH_OP) || (state_q == FETCH_ADDR) ||
                      (state_q == FETCH_DH) || (state_q == FETCH_DL);
    // pend_q marks the capture cycle that follows a pop.
    assign byte_rdy = is_fetch && pend_q;

    always_comb begin
        state_d           = state_q;
        pend_d            = pend_q;
        op_d              = op_q;
        hi_d              = hi_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        uart_out_read     = 1'b0;
        uart_in_write     = 1'b0;
        uart_data_in      = '0;
        uart_rst          = 1'b0;
        settings_write_en = 1'b0;

        if (is_fetch) begin
            if (pend_q) begin
                pend_d = 1'b0;
            end else if (!uart_out_empty) begin
                uart_out_read = 1'b1;
                pend_d        = 1'b1;
            end
        end

        case (state_q)
            IDLE:       state_d = FETCH_OP;
            FETCH_OP: begin
                if (byte_rdy) begin
                    op_d    = uart_data_out;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (op_q == OP_UARTRST) begin
                    state_d = UART_RESET;
                end else if (op_q == OP_WRITEREG || op_q == OP_READREG) begin
                    state_d = FETCH_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH_ADDR: begin
                if (byte_rdy) begin
                    addr_d  = SETTINGS_ADDR_WIDTH'(uart_data_out);
                    state_d = (op_q == OP_WRITEREG) ? FETCH_DH : REG_READ;
                end
            end
            FETCH_DH: begin
                if (byte_rdy) begin
                    hi_d    = uart_data_out;
                    state_d = FETCH_DL;
                end
            end
            FETCH_DL: begin
                if (byte_rdy) begin
                    wdata_d = SETTINGS_DATA_WIDTH'({hi_q, uart_data_out});
                    state_d = REG_WRITE;
                end
            end
            REG_WRITE: begin
                settings_write_en = 1'b1;
                state_d           = IDLE;
            end
            // Address is already on settings_addr; the bank answers one cycle later.
            REG_READ:   state_d = READ_WAIT;
            READ_WAIT: begin
                rdata_d = settings_data_in;
                state_d = SEND_HI;
            end
            SEND_HI: begin
                uart_data_in = rdata_q[SETTINGS_DATA_WIDTH-1 -: BUFFER_WIDTH];
                if (!uart_in_full) begin
                    uart_in_write = 1'b1;
                    state_d       = SEND_LO;
                end
            end
            SEND_LO: begin
                uart_data_in = rdata_q[BUFFER_WIDTH-1:0];
                if (!uart_in_full) begin
                    uart_in_write = 1'b1;
                    state_d       = IDLE;
                end
            end
            UART_RESET: begin
                uart_rst = 1'b1;
                state_d  = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            op_q    <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign settings_addr     = addr_q;
    assign settings_data_out = wdata_q;

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Bench for uart_cmd_handler: RX FIFO and register-bank models, scoreboarded TX bytes and register writes.
`timescale 1ns/1ps
module tb_uart_cmd_handler;

    logic        clk = 1'b0;
    logic        rstb;
    logic        uart_rst;
    logic [7:0]  uart_data_out = 8'h00;
    logic        uart_out_empty;
    logic        uart_out_read;
    logic [7:0]  uart_data_in;
    logic        uart_in_write;
    logic        uart_in_full;
    logic [7:0]  settings_addr;
    logic [15:0] settings_data_in = 16'h0000;
    logic [15:0] settings_data_out;
    logic        settings_write_en;

    uart_cmd_handler dut (
        .clk               (clk),
        .rstb              (rstb),
        .uart_rst          (uart_rst),
        .uart_data_out     (uart_data_out),
        .uart_out_full     (1'b0),
        .uart_out_empty    (uart_out_empty),
        .uart_out_read     (uart_out_read),
        .uart_data_in      (uart_data_in),
        .uart_in_write     (uart_in_write),
        .uart_in_full      (uart_in_full),
        .uart_in_empty     (1'b1),
        .settings_addr     (settings_addr),
        .settings_data_in  (settings_data_in),
        .settings_data_out (settings_data_out),
        .settings_write_en (settings_write_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // RX FIFO model: stimulus owns wr_idx, the pop process owns rd_idx.
    logic [7:0] rx_mem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    assign uart_out_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (uart_out_read && rd_idx != wr_idx) begin
            uart_data_out <= rx_mem[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    // Register bank with one-cycle read latency; unwritten addresses return a fixed pattern.
    logic [15:0] bank [0:255];
    logic        bank_wr [0:255];
    initial for (int i = 0; i < 256; i++) bank_wr[i] = 1'b0;

    function automatic logic [15:0] bank_default(input logic [7:0] a);
        if (a == 8'hA0) return 16'hC5C5;
        if (a == 8'hA1) return 16'h12AB;
        return {~a, a};
    endfunction

    always @(posedge clk) begin
        settings_data_in <= bank_wr[settings_addr] ? bank[settings_addr] : bank_default(settings_addr);
        if (settings_write_en) begin
            bank[settings_addr]    <= settings_data_out;
            bank_wr[settings_addr] <= 1'b1;
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [7:0]  tx_obs [0:63];
    logic [23:0] wr_obs [0:63];
    int tx_cnt  = 0;
    int wr_cnt  = 0;
    int rst_cnt = 0;
    int pop_cnt = 0;
    int viol    = 0;
    logic rst_prev = 1'b0;

    always @(negedge clk) begin
        if (uart_out_read) begin
            pop_cnt++;
            if (uart_out_empty) viol++;
        end
        if (uart_in_write) begin
            if (uart_in_full) viol++;
            tx_obs[tx_cnt] = uart_data_in;
            tx_cnt++;
        end
        if (settings_write_en) begin
            wr_obs[wr_cnt] = {settings_addr, settings_data_out};
            wr_cnt++;
        end
        if (uart_rst) begin
            rst_cnt++;
            if (rst_prev) viol++;
        end
        rst_prev = uart_rst;
    end

    // Scoreboard
    logic [7:0]  exp_tx [$];
    logic [23:0] exp_wr [$];
    int tx_rd   = 0;
    int wr_rd   = 0;
    int rst_exp = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_mem[wr_idx] = b;
        wr_idx++;
    endtask

    task automatic drain_check(input string tag);
        logic [7:0]  et;
        logic [23:0] ew;
        cyc(40);
        check_eq({tag, "_ntx"}, 32'(tx_cnt - tx_rd), 32'(exp_tx.size()));
        while (tx_rd < tx_cnt && exp_tx.size() > 0) begin
            et = exp_tx.pop_front();
            check_eq({tag, "_tx"}, 32'(tx_obs[tx_rd]), 32'(et));
            tx_rd++;
        end
        check_eq({tag, "_nwr"}, 32'(wr_cnt - wr_rd), 32'(exp_wr.size()));
        while (wr_rd < wr_cnt && exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            check_eq({tag, "_wr"}, 32'(wr_obs[wr_rd]), 32'(ew));
            wr_rd++;
        end
        tx_rd = tx_cnt;
        wr_rd = wr_cnt;
        exp_tx.delete();
        exp_wr.delete();
        check_eq({tag, "_rst"}, 32'(rst_cnt), 32'(rst_exp));
        check_eq({tag, "_pops"}, 32'(pop_cnt), 32'(wr_idx));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {28'd0, uart_rst, uart_out_read, uart_in_write, settings_write_en}, 32'd0);
        check_eq({tag, "_txd"}, 32'(uart_data_in), 32'd0);
        check_eq({tag, "_addr"}, 32'(settings_addr), 32'd0);
        check_eq({tag, "_wdat"}, 32'(settings_data_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb         = 1'b0;
        uart_in_full = 1'b0;
        cyc(3);
        check_outputs_zero("in_reset");
        rstb = 1'b1;
        cyc(10);
        check_outputs_zero("post_reset");
        check_eq("post_reset_pops", 32'(pop_cnt), 32'd0);

        // UARTRST
        feed(8'h01);
        rst_exp++;
        drain_check("uartrst");

        // WRITEREG 0x0F <= 0x1234
        feed(8'h02); feed(8'h0F); feed(8'h12); feed(8'h34);
        exp_wr.push_back({8'h0F, 16'h1234});
        drain_check("writereg");

        // READREG 0xA0 -> 0xC5C5
        feed(8'h03); feed(8'hA0);
        exp_tx.push_back(8'hC5); exp_tx.push_back(8'hC5);
        drain_check("readreg");
        check_eq("readreg_addr_hold", 32'(settings_addr), 32'hA0);
        check_eq("wdata_hold", 32'(settings_data_out), 32'h1234);

        // READREG 0xA1 -> 0x12AB with TX full stalling the reply
        uart_in_full = 1'b1;
        feed(8'h03); feed(8'hA1);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'hAB);
        cyc(14);
        check_eq("stall_no_push", 32'(tx_cnt - tx_rd), 32'd0);
        check_eq("stall_addr", 32'(settings_addr), 32'hA1);
        uart_in_full = 1'b0;
        drain_check("stall");

        // Unknown opcode followed by UARTRST
        feed(8'h7E); feed(8'h01);
        rst_exp++;
        drain_check("unknown_op");

        // Read back the register written earlier
        feed(8'h03); feed(8'h0F);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        drain_check("readback");

        // Reset in the middle of a WRITEREG frame, after the addr byte
        feed(8'h02); feed(8'h55);
        cyc(10);
        check_eq("abort_pops", 32'(pop_cnt), 32'(wr_idx));
        rstb = 1'b0;
        cyc(2);
        check_outputs_zero("abort_reset");
        rstb = 1'b1;
        cyc(2);
        feed(8'h02); feed(8'h33); feed(8'hBE); feed(8'hEF);
        exp_wr.push_back({8'h33, 16'hBEEF});
        drain_check("after_abort");

        check_eq("protocol_violations", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
